// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard sequencer and the branch/jump control.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      MEM_ERR  = 2'b10
   } state_t;

   localparam logic [1:0] JB_NONE   = 2'b00;
   localparam logic [1:0] JB_BRANCH = 2'b01;
   localparam logic [1:0] JB_JUMP   = 2'b10;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_bubble;
      logic exmem_hold;
      logic memwb_bubble;
   } ctl_t;

   localparam ctl_t CTL_RESET  = 6'b001101;
   localparam ctl_t CTL_FREEZE = 6'b000011;
   localparam ctl_t CTL_STALL  = 6'b000100;
   localparam ctl_t CTL_FLUSH  = 6'b111000;
   localparam ctl_t CTL_NORMAL = 6'b110000;

   // $0 is hard-wired, so a dependency on it is never real.
   function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
      return (a != REG_ZERO) && (a == b);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational operand-dependency comparators for the ID-stage instruction.
module hazard_detect
   import hazard_pkg::*;
(
   input  logic       id_is_branch,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       ex_memread,
   input  logic       ex_regwrite,
   input  logic [4:0] ex_wreg,
   input  logic       mem_memread,
   input  logic [4:0] mem_wreg,
   output logic       load_use,
   output logic       br_ex,
   output logic       br_mem
);

   logic ex_rs_s;
   logic ex_rt_s;
   logic mem_rs_s;
   logic mem_rt_s;

   assign ex_rs_s  = reg_match(ex_wreg, id_rs);
   assign ex_rt_s  = reg_match(ex_wreg, id_rt);
   assign mem_rs_s = reg_match(mem_wreg, id_rs);
   assign mem_rt_s = reg_match(mem_wreg, id_rt);

   // Branches compare both operands in ID, so rt counts regardless of id_uses_rt.
   assign load_use = ex_memread & (ex_rs_s | (id_uses_rt & ex_rt_s));
   assign br_ex    = id_is_branch & ex_regwrite & (ex_rs_s | ex_rt_s);
   assign br_mem   = id_is_branch & mem_memread & (mem_rs_s | mem_rt_s);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline advance/hold/flush/bubble controller with a data-memory wait FSM
// and saturating stall/flush counters.
module hazard_sequencer
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_is_branch,
   input  logic [1:0]       jb_flag,
   input  logic             ex_memread,
   input  logic             ex_regwrite,
   input  logic [4:0]       ex_wreg,
   input  logic             mem_memread,
   input  logic [4:0]       mem_wreg,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             exmem_hold,
   output logic             memwb_bubble,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_r;
   logic [TMR_W-1:0] timer_r;
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;

   logic load_use_s;
   logic br_ex_s;
   logic br_mem_s;
   logic stall_s;
   logic mem_wait_s;
   logic jb_take_s;
   ctl_t ctl_s;

   hazard_detect u_detect (
      .id_is_branch (id_is_branch),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rt   (id_uses_rt),
      .ex_memread   (ex_memread),
      .ex_regwrite  (ex_regwrite),
      .ex_wreg      (ex_wreg),
      .mem_memread  (mem_memread),
      .mem_wreg     (mem_wreg),
      .load_use     (load_use_s),
      .br_ex        (br_ex_s),
      .br_mem       (br_mem_s)
   );

   assign stall_s    = load_use_s | br_ex_s | br_mem_s;
   assign mem_wait_s = mem_req & ~mem_ready;
   assign jb_take_s  = (jb_flag == JB_BRANCH) | (jb_flag == JB_JUMP);

   // Control outputs: memory freeze beats hazard stall, which beats a jump/branch flush.
   always_comb begin
      ctl_s = CTL_FREEZE;
      if (reset) begin
         ctl_s = CTL_RESET;
      end else begin
         case (state_r)
            RUN: begin
               if (mem_wait_s) begin
                  ctl_s = CTL_FREEZE;
               end else if (stall_s) begin
                  ctl_s = CTL_STALL;
               end else if (jb_take_s) begin
                  ctl_s = CTL_FLUSH;
               end else begin
                  ctl_s = CTL_NORMAL;
               end
            end
            MEM_WAIT: ctl_s = CTL_FREEZE;
            MEM_ERR:  ctl_s = CTL_FREEZE;
            default:  ctl_s = CTL_FREEZE;
         endcase
      end
   end

   assign pc_write     = ctl_s.pc_write;
   assign ifid_write   = ctl_s.ifid_write;
   assign ifid_flush   = ctl_s.ifid_flush;
   assign idex_bubble  = ctl_s.idex_bubble;
   assign exmem_hold   = ctl_s.exmem_hold;
   assign memwb_bubble = ctl_s.memwb_bubble;
   assign mem_error    = (state_r == MEM_ERR);
   assign stall_count  = stall_cnt_r;
   assign flush_count  = flush_cnt_r;

   // Sequencer state, memory wait timer and performance counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= RUN;
         timer_r     <= '0;
         stall_cnt_r <= '0;
         flush_cnt_r <= '0;
      end else begin
         case (state_r)
            RUN: begin
               if (mem_wait_s) begin
                  state_r <= MEM_WAIT;
                  timer_r <= TMR_W'(1);
               end else if (stall_s) begin
                  if (stall_cnt_r != CNT_MAX) begin
                     stall_cnt_r <= stall_cnt_r + CNT_W'(1);
                  end
               end else if (jb_take_s) begin
                  if (flush_cnt_r != CNT_MAX) begin
                     flush_cnt_r <= flush_cnt_r + CNT_W'(1);
                  end
               end
            end
            MEM_WAIT: begin
               // A withdrawn request is treated as completed.
               if (mem_ready || !mem_req) begin
                  state_r <= RUN;
               end else if (timer_r == TMR_MAX) begin
                  state_r <= MEM_ERR;
               end else begin
                  timer_r <= timer_r + TMR_W'(1);
               end
            end
            MEM_ERR: state_r <= MEM_ERR;
            default: state_r <= RUN;
         endcase
      end
   end

endmodule
